// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the RAM responder: bus word, bus state and latency limit.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int LAT_MAX = 15;

endpackage

// File: rtl/ram_responder_if.sv
// Request/response bus between a CPU-side requester (master) and the RAM responder (slave).
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
  modport slave  (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);

endinterface

// File: rtl/ram_array.sv
// Word storage with a bus write port, a backdoor write port that wins on a shared index,
// and an asynchronous read port. Contents are never reset.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               bus_we,
  input  logic [DEPTH_W-1:0] bus_idx,
  input  word_t              bus_data,
  input  logic               init_we,
  input  logic [DEPTH_W-1:0] init_idx,
  input  word_t              init_data,
  input  logic [DEPTH_W-1:0] rd_idx,
  output word_t              rd_data
);

  word_t mem [2**DEPTH_W];

  // Backdoor is written last so it takes the index when both target the same word.
  always_ff @(posedge clk) begin
    if (bus_we)  mem[bus_idx]  <= bus_data;
    if (init_we) mem[init_idx] <= init_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ram_responder.sv
// Latency-modelled RAM slave: a held request reaches ACCESS after LAT cycles, any request
// change restarts the count, and each ACCESS moves exactly one word.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT     = 2,
  parameter int DEPTH_W = 10
) (
  input  logic           CLK,
  input  logic           RST,
  ram_responder_if.slave bus,
  input  logic           init_wen,
  input  word_t          init_addr,
  input  word_t          init_data,
  output word_t          reads_done,
  output word_t          writes_done
);

  localparam logic [3:0] LAT_C = 4'((LAT > LAT_MAX) ? LAT_MAX : LAT);

  logic [3:0]         cnt;
  logic [3:0]         cnt_eff;
  logic               ren_p1;
  logic               wen_p1;
  word_t              addr_p1;
  logic               req_vld;
  logic               req_err;
  logic               req_chg;
  logic               access;
  logic               rd_access;
  logic               wr_access;
  logic [DEPTH_W-1:0] bus_idx;
  word_t              rd_data;
  logic               unused_init;

  function automatic word_t sat_inc(input word_t v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign req_vld   = bus.ramREN ^ bus.ramWEN;
  assign req_err   = bus.ramREN & bus.ramWEN;
  // A request that differs from last cycle's is a new transaction, so it sees a zero count.
  assign req_chg   = (bus.ramREN != ren_p1) || (bus.ramWEN != wen_p1) || (bus.ramaddr != addr_p1);
  assign cnt_eff   = req_chg ? 4'd0 : cnt;
  assign access    = req_vld && (cnt_eff == LAT_C);
  assign rd_access = access && bus.ramREN;
  assign wr_access = access && bus.ramWEN;
  assign bus_idx   = bus.ramaddr[DEPTH_W+1:2];

  assign bus.ramstate = req_err  ? ERROR :
                        !req_vld ? FREE  :
                        access   ? ACCESS : BUSY;
  assign bus.ramload  = rd_access ? rd_data : '0;

  assign unused_init = ^init_addr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= 4'd0;
      ren_p1      <= 1'b0;
      wen_p1      <= 1'b0;
      addr_p1     <= '0;
      reads_done  <= '0;
      writes_done <= '0;
    end else begin
      ren_p1  <= bus.ramREN;
      wen_p1  <= bus.ramWEN;
      addr_p1 <= bus.ramaddr;
      if (!req_vld || access) cnt <= 4'd0;
      else                    cnt <= cnt_eff + 4'd1;
      if (rd_access) reads_done  <= sat_inc(reads_done);
      if (wr_access) writes_done <= sat_inc(writes_done);
    end
  end

  ram_array #(
    .DEPTH_W(DEPTH_W)
  ) u_array (
    .clk      (CLK),
    .bus_we   (wr_access && !RST),
    .bus_idx  (bus_idx),
    .bus_data (bus.ramstore),
    .init_we  (init_wen),
    .init_idx (init_addr[DEPTH_W+1:2]),
    .init_data(init_data),
    .rd_idx   (bus_idx),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus queues expected ACCESS events from a
// word-indexed memory model, a negedge monitor pops and compares them.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int LAT     = 2;
  localparam int DEPTH_W = 10;

  typedef struct {
    bit    rd;
    word_t data;
    int    cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  init_wen;
  word_t init_addr;
  word_t init_data;
  word_t reads_done;
  word_t writes_done;

  ram_responder_if bus();

  ram_responder #(
    .LAT    (LAT),
    .DEPTH_W(DEPTH_W)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .init_wen   (init_wen),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .reads_done (reads_done),
    .writes_done(writes_done)
  );

  always #5 clk = ~clk;

  int    cycle = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  exp_t  m_e;
  word_t mdl [int];
  int    n_rd = 0;
  int    n_wr = 0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int idx_of(input word_t a);
    return int'((a >> 2) % (32'd1 << DEPTH_W));
  endfunction

  function automatic word_t mem_rd(input word_t a);
    return mdl.exists(idx_of(a)) ? mdl[idx_of(a)] : 32'h0;
  endfunction

  // Monitor: every ACCESS must match the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ramstate == ACCESS) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("access_kind", 32'(bus.ramREN), 32'(m_e.rd));
          check("access_cycle", 32'(cycle), 32'(m_e.cyc));
          check(m_e.rd ? "read_data" : "write_load", bus.ramload, m_e.data);
        end
      end else begin
        check("idle_load", bus.ramload, 32'h0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic backdoor(input word_t a, input word_t d);
    init_wen  = 1'b1;
    init_addr = a;
    init_data = d;
    mdl[idx_of(a)] = d;
    cyc();
    init_wen = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_reads"}, reads_done, 32'(n_rd));
    check({tag, "_writes"}, writes_done, 32'(n_wr));
  endtask

  task automatic txn(input bit rd, input word_t a, input word_t d);
    exp_t e;
    bus.ramREN   = rd;
    bus.ramWEN   = !rd;
    bus.ramaddr  = a;
    bus.ramstore = d;
    e.rd   = rd;
    e.cyc  = cycle + LAT;
    e.data = rd ? mem_rd(a) : 32'h0;
    exp_q.push_back(e);
    for (int i = 0; i <= LAT; i++) begin
      if (i < LAT) begin
        @(negedge clk);
        check("busy_state", 32'(bus.ramstate), 32'(BUSY));
      end
      cyc();
    end
    if (rd) n_rd++;
    else begin
      n_wr++;
      mdl[idx_of(a)] = d;
    end
    check_counters("txn");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit    rd;
    int    ix;
    word_t a;
    word_t d;
    int    w;

    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    init_wen = 1'b0;
    init_addr = '0;
    init_data = '0;

    repeat (2) begin
      @(negedge clk);
      check("reset_state", 32'(bus.ramstate), 32'(FREE));
      check("reset_load", bus.ramload, 32'h0);
      check_counters("reset");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 32; i++) backdoor(word_t'(i) << 2, $urandom);

    // Basic read with latency
    backdoor(32'h100, 32'hDEADBEEF);
    txn(1'b1, 32'h100, 32'h0);

    // Write then read back
    txn(1'b0, 32'h200, 32'h12345678);
    txn(1'b1, 32'h200, 32'h0);

    // Address change mid-count restarts the transaction
    backdoor(32'h104, 32'h13579BDF);
    bus.ramREN = 1'b1;
    bus.ramWEN = 1'b0;
    bus.ramaddr = 32'h100;
    cyc();
    txn(1'b1, 32'h104, 32'h0);

    // Both strobes: ERROR, no write, no counting
    backdoor(32'h300, 32'hCAFEF00D);
    bus.ramREN = 1'b1;
    bus.ramWEN = 1'b1;
    bus.ramaddr = 32'h300;
    bus.ramstore = 32'h0BAD0BAD;
    repeat (LAT + 2) begin
      @(negedge clk);
      check("error_state", 32'(bus.ramstate), 32'(ERROR));
      cyc();
    end
    idle(1);
    @(negedge clk);
    check("free_state", 32'(bus.ramstate), 32'(FREE));
    check_counters("error");
    cyc();
    txn(1'b1, 32'h300, 32'h0);

    // Address aliasing above the index bits
    txn(1'b0, 32'h1004, 32'hA5A5A5A5);
    txn(1'b1, 32'h0004, 32'h0);

    // Backdoor and bus write to the same word on the same edge
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b1;
    bus.ramaddr = 32'h500;
    bus.ramstore = 32'h11111111;
    m_e.rd = 1'b0;
    m_e.data = 32'h0;
    m_e.cyc = cycle + LAT;
    exp_q.push_back(m_e);
    repeat (LAT) cyc();
    init_wen = 1'b1;
    init_addr = 32'h500;
    init_data = 32'h22222222;
    cyc();
    init_wen = 1'b0;
    n_wr++;
    mdl[idx_of(32'h500)] = 32'h22222222;
    txn(1'b1, 32'h500, 32'h0);

    // Randomized traffic with occasional aborted prefixes
    for (int k = 0; k < 60; k++) begin
      rd = 1'($urandom_range(0, 1));
      ix = $urandom_range(0, 31);
      a  = ($urandom & 32'hFFFF_F003) | (word_t'(ix) << 2);
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        bus.ramREN = 1'($urandom_range(0, 1));
        bus.ramWEN = !bus.ramREN;
        bus.ramaddr = a ^ 32'h4;
        bus.ramstore = ~d;
        repeat ($urandom_range(1, LAT)) cyc();
      end
      txn(rd, a, d);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    // Reset during a write's BUSY phase drops the write
    backdoor(32'h400, 32'h0);
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b1;
    bus.ramaddr = 32'h400;
    bus.ramstore = 32'hFFFF0000;
    cyc();
    @(negedge clk);
    rst = 1'b1;
    bus.ramWEN = 1'b0;
    #1;
    check("rst_reads", reads_done, 32'h0);
    check("rst_writes", writes_done, 32'h0);
    check("rst_state", 32'(bus.ramstate), 32'(FREE));
    cyc();
    cyc();
    rst = 1'b0;
    n_rd = 0;
    n_wr = 0;
    idle(1);
    txn(1'b1, 32'h400, 32'h0);
    idle(2);

    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      cyc();
      w++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning cycles from a stable request to ACCESS (legal 0..15).
REQ-002 SHALL have parameter DEPTH_W, default 10, meaning log2 of the number of 32-bit words stored.
REQ-003 SHALL have port CLK  in  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port ramREN  in  1  bus read request.
REQ-006 SHALL have port ramWEN  in  1  bus write request.
REQ-007 SHALL have port ramaddr  in  32  byte address.
REQ-008 SHALL have port ramstore  in  32  write data.
REQ-009 SHALL have port ramload  out  32  read data.
REQ-010 SHALL have port ramstate  out  ramstate_t  FREE/BUSY/ACCESS/ERROR.
REQ-011 SHALL have port init_wen  in  1  testbench backdoor write strobe.
REQ-012 SHALL have port init_addr  in  32  backdoor byte address.
REQ-013 SHALL have port init_data  in  32  backdoor write data.
REQ-014 SHALL have port reads_done  out  32  count of completed reads.
REQ-015 SHALL have port writes_done  out  32  count of completed writes.

Function
REQ-016 Word index SHALL be ramaddr[DEPTH_W+1:2]; bits [1:0] and bits above DEPTH_W+1 are ignored (aliasing wrap-around).
REQ-017 Request = exactly one of ramREN/ramWEN high; both high SHALL give ramstate=ERROR, no write, counter cleared.
REQ-018 Neither high SHALL give ramstate=FREE, counter cleared.
REQ-019 Registered 4-bit counter cnt; ramstate SHALL be ACCESS when request valid and cnt==LAT, else BUSY (combinational from cnt and inputs).
REQ-020 While request valid and cnt<LAT, cnt SHALL increment each cycle.
REQ-021 Request held stable from cycle t SHALL see ACCESS in cycle t+LAT; LAT=0 gives ACCESS in cycle t.
REQ-022 After an ACCESS cycle cnt SHALL return to 0, so a request still held (same or new address) starts a new transaction; each ACCESS transfers exactly one word.
REQ-023 Any change of ramaddr, ramREN or ramWEN while BUSY SHALL abort the transaction and restart the count from 0 with the new request.
REQ-024 Read: during ACCESS with ramREN, ramload SHALL equal mem[index]; otherwise ramload SHALL be 0.
REQ-025 Write: mem[index] SHALL take ramstore at the rising edge ending the ACCESS cycle; no write during BUSY/ERROR/FREE.
REQ-026 init_wen SHALL write init_data to mem[init_addr index] at the next edge, in any state; on the same index in the same cycle as a bus write, backdoor SHALL win.
REQ-027 Read-after-write to same index SHALL return the new data in the next transaction's ACCESS.
REQ-028 reads_done/writes_done SHALL increment on each read/write ACCESS cycle and saturate at 32'hFFFFFFFF.

Reset
REQ-029 While RST high: cnt=0, reads_done=0, writes_done=0, so ramstate follows REQ-017/018 with cnt=0 and ramload=0 unless LAT=0.
REQ-030 Reset mid-transaction SHALL discard it; a pending write SHALL not commit.
REQ-031 Memory contents SHALL not be reset; unwritten locations are undefined.

Structure
REQ-032 ramstate_t and word_t SHALL come from cpu_types_pkg; no new package types.
REQ-033 Storage SHALL be a sub-module ram_array (one write port with backdoor priority, one async read port).
REQ-034 Constant LAT_MAX=15 SHALL live in cpu_types_pkg.

Verification
REQ-035 LAT=2, backdoor 0x100<=0xDEADBEEF, ramREN@0x100 at t -> BUSY t,t+1; ACCESS t+2, ramload=0xDEADBEEF; reads_done=1.
REQ-036 LAT=2, ramWEN@0x200 ramstore=0x12345678 held 3 cycles, then ramREN@0x200 -> read ACCESS returns 0x12345678; writes_done=1.
REQ-037 ramREN@0x100 changed to 0x104 at cnt=1 -> count restarts, ACCESS 2 cycles after change, data of 0x104.
REQ-038 ramREN and ramWEN both high with ramaddr=0x300 -> ERROR; mem[0x300] unchanged; counters unchanged.
REQ-039 DEPTH_W=10: write 0x1004 with 0xA5A5A5A5 -> read of 0x0004 returns 0xA5A5A5A5 (alias).
REQ-040 RST pulsed during write BUSY to 0x400 holding 0x0 -> after reset mem[0x400]=0x0, cnt=0, counters 0.
